// File: rtl/pim_mvm_if.sv
// ============================================================================
// pim_mvm_if : host, crossbar and result-path signals of the PIM MVM engine
// Rev 1.0
// ============================================================================
`default_nettype none

interface pim_mvm_if #(
  parameter int INPUT_SIZE = 32,
  parameter int INPUT_P    = 16,
  parameter int AW         = 5,
  parameter int W_SLICES   = 2,
  parameter int ADC_P      = 8,
  parameter int OUT_P      = 16
);
  logic                          start;
  logic [AW-1:0]                 start_col;
  logic [AW-1:0]                 end_col;
  logic [INPUT_SIZE*INPUT_P-1:0] vec_in;
  logic                          busy;
  logic                          xbar_en;
  logic [AW-1:0]                 xbar_addr;
  logic [INPUT_SIZE-1:0]         xbar_bits;
  logic [W_SLICES*ADC_P-1:0]     xbar_res;
  logic                          out_valid;
  logic                          out_ready;
  logic [OUT_P-1:0]              out_data;
  logic [AW-1:0]                 out_col;
  logic                          out_sat;
  logic                          done;
  logic                          err;

  modport master (
    output start, start_col, end_col, vec_in, xbar_res, out_ready,
    input  busy, xbar_en, xbar_addr, xbar_bits, out_valid, out_data, out_col,
           out_sat, done, err
  );

  modport slave (
    input  start, start_col, end_col, vec_in, xbar_res, out_ready,
    output busy, xbar_en, xbar_addr, xbar_bits, out_valid, out_data, out_col,
           out_sat, done, err
  );
endinterface

`default_nettype wire

// File: rtl/pim_mvm_engine.sv
// ============================================================================
// pim_mvm_engine : bit-serial matrix-vector column sweep over a PIM crossbar
// Rev 1.0
// ============================================================================
`default_nettype none

module pim_mvm_engine #(
  parameter int INPUT_SIZE = 32,
  parameter int INPUT_P    = 16,
  parameter int DEPTH      = 32,
  parameter int W_SLICES   = 2,
  parameter int WS_P       = 8,
  parameter int ADC_P      = 8,
  parameter int OUT_P      = 16,
  parameter int XBAR_LAT   = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  pim_mvm_if.slave  bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = (INPUT_P > 1) ? $clog2(INPUT_P) : 1;
  localparam int SW    = $clog2(W_SLICES);
  localparam int ACC_W = ADC_P + WS_P*(W_SLICES-1) + INPUT_P + SW;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_OUT   = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t                        r_state, w_next;
  logic [INPUT_SIZE*INPUT_P-1:0] r_vec;
  logic [AW-1:0]                 r_col, r_end;
  logic [BW-1:0]                 r_bcnt, r_accb;
  logic [XBAR_LAT-1:0]           r_vpipe;
  logic [ACC_W-1:0]              r_acc;
  logic                          r_err;

  logic                  w_busy, w_en, w_valid, w_done, w_accept;
  logic                  w_bad, w_last_bit, w_drain_last, w_ovf;
  logic [XBAR_LAT-1:0]   w_pipe_rest;
  logic [INPUT_SIZE-1:0] w_bits;
  logic [INPUT_P-1:0]    w_elem;
  logic [ACC_W-1:0]      w_slice_sum, w_term;
  logic [OUT_P-1:0]      w_clip;

  assign w_bad      = (bus.end_col < bus.start_col) || (32'(bus.end_col) >= 32'(DEPTH));
  assign w_last_bit = (r_bcnt == BW'(INPUT_P-1));

  // Drain ends once only the oldest pipe stage still holds an outstanding result.
  always_comb begin
    w_pipe_rest               = r_vpipe;
    w_pipe_rest[XBAR_LAT-1]   = 1'b0;
    w_drain_last              = (w_pipe_rest == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_busy   = 1'b0;
    w_en     = 1'b0;
    w_valid  = 1'b0;
    w_done   = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && !w_bad) begin
          w_accept = 1'b1;
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_busy = 1'b1;
        w_en   = 1'b1;
        if (w_last_bit) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (w_drain_last) w_next = S_OUT;
      end
      S_OUT: begin
        w_busy  = 1'b1;
        w_valid = 1'b1;
        if (bus.out_ready) w_next = (r_col == r_end) ? S_FIN : S_ISSUE;
      end
      S_FIN: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec   <= '0;
      r_col   <= '0;
      r_end   <= '0;
      r_bcnt  <= '0;
      r_accb  <= '0;
      r_vpipe <= '0;
      r_acc   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err   <= (r_state == S_IDLE) && bus.start && w_bad;
      r_vpipe <= (r_vpipe << 1) | XBAR_LAT'(w_en);

      if (w_accept) begin
        r_vec <= bus.vec_in;
        r_col <= bus.start_col;
        r_end <= bus.end_col;
      end else if ((r_state == S_OUT) && bus.out_ready && (r_col != r_end)) begin
        r_col <= r_col + AW'(1);
      end

      if (r_state == S_ISSUE) r_bcnt <= w_last_bit ? '0 : r_bcnt + BW'(1);

      // Results come back in issue order, so a local plane counter tracks the shift.
      if ((r_state == S_ISSUE) && (r_bcnt == '0)) begin
        r_acc  <= '0;
        r_accb <= '0;
      end else if (r_vpipe[XBAR_LAT-1]) begin
        r_acc  <= r_acc + w_term;
        r_accb <= r_accb + BW'(1);
      end
    end
  end

  always_comb begin
    w_bits = '0;
    w_elem = '0;
    for (int i = 0; i < INPUT_SIZE; i++) begin
      w_elem    = r_vec[i*INPUT_P +: INPUT_P];
      w_bits[i] = w_elem[r_bcnt];
    end
  end

  always_comb begin
    w_slice_sum = '0;
    for (int s = 0; s < W_SLICES; s++)
      w_slice_sum = w_slice_sum + (ACC_W'(bus.xbar_res[s*ADC_P +: ADC_P]) << (s*WS_P));
  end

  assign w_term = w_slice_sum << r_accb;

  generate
    if (ACC_W > OUT_P) begin : g_sat
      assign w_ovf = |r_acc[ACC_W-1:OUT_P];
    end else begin : g_nosat
      assign w_ovf = 1'b0;
    end
  endgenerate

  assign w_clip = w_ovf ? '1 : OUT_P'(r_acc);

  assign bus.busy      = w_busy;
  assign bus.xbar_en   = w_en;
  assign bus.xbar_addr = w_en ? r_col : '0;
  assign bus.xbar_bits = w_en ? w_bits : '0;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_valid ? w_clip : '0;
  assign bus.out_col   = w_valid ? r_col : '0;
  assign bus.out_sat   = w_valid & w_ovf;
  assign bus.done      = w_done;
  assign bus.err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_pim_mvm_engine.sv
// ============================================================================
// tb_pim_mvm_engine : scoreboard bench with a latency-1 crossbar model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pim_mvm_engine;
  localparam int INPUT_SIZE = 4;
  localparam int INPUT_P    = 4;
  localparam int DEPTH      = 8;
  localparam int W_SLICES   = 2;
  localparam int WS_P       = 4;
  localparam int ADC_P      = 8;
  localparam int XBAR_LAT   = 1;
  localparam int AW         = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   k0 = 1;
  int   k1 = 0;

  typedef struct {
    int col;
    int d16;
    int s16;
    int d8;
    int s8;
  } exp_t;
  exp_t sb_q[$];

  pim_mvm_if #(.INPUT_SIZE(INPUT_SIZE), .INPUT_P(INPUT_P), .AW(AW), .W_SLICES(W_SLICES),
               .ADC_P(ADC_P), .OUT_P(16)) bus16 ();
  pim_mvm_if #(.INPUT_SIZE(INPUT_SIZE), .INPUT_P(INPUT_P), .AW(AW), .W_SLICES(W_SLICES),
               .ADC_P(ADC_P), .OUT_P(8)) bus8 ();

  pim_mvm_engine #(.INPUT_SIZE(INPUT_SIZE), .INPUT_P(INPUT_P), .DEPTH(DEPTH), .W_SLICES(W_SLICES),
                   .WS_P(WS_P), .ADC_P(ADC_P), .OUT_P(16), .XBAR_LAT(XBAR_LAT))
    u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
  pim_mvm_engine #(.INPUT_SIZE(INPUT_SIZE), .INPUT_P(INPUT_P), .DEPTH(DEPTH), .W_SLICES(W_SLICES),
                   .WS_P(WS_P), .ADC_P(ADC_P), .OUT_P(8), .XBAR_LAT(XBAR_LAT))
    u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  assign bus8.start     = bus16.start;
  assign bus8.start_col = bus16.start_col;
  assign bus8.end_col   = bus16.end_col;
  assign bus8.vec_in    = bus16.vec_in;
  assign bus8.xbar_res  = bus16.xbar_res;
  assign bus8.out_ready = bus16.out_ready;

  always #5 clk = ~clk;

  // Crossbar model: slice s = popcount(bits) * k_s one cycle later, junk when idle.
  always @(posedge clk) begin
    int pc;
    pc = $countones(bus16.xbar_bits);
    if (bus16.xbar_en) bus16.xbar_res <= {8'(pc*k1), 8'(pc*k0)};
    else               bus16.xbar_res <= 16'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int vec_sum(input logic [15:0] v);
    int s = 0;
    for (int i = 0; i < INPUT_SIZE; i++) s += int'(v[i*INPUT_P +: INPUT_P]);
    return s;
  endfunction

  task automatic push_exp(input int sc, input int ec, input logic [15:0] v);
    exp_t e;
    int   tot;
    tot = vec_sum(v) * (k0 + (k1 << WS_P));
    for (int c = sc; c <= ec; c++) begin
      e.col = c;
      e.s16 = (tot > 65535) ? 1 : 0;
      e.d16 = (tot > 65535) ? 65535 : tot;
      e.s8  = (tot > 255) ? 1 : 0;
      e.d8  = (tot > 255) ? 255 : tot;
      sb_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus16.xbar_en && sb_q.size() > 0) chk("xbar_addr", bus16.xbar_addr, sb_q[0].col);
      if (bus16.out_valid && bus16.out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out_col", bus16.out_col, 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("out_col", bus16.out_col, e.col);
          chk("out_data16", bus16.out_data, e.d16);
          chk("out_sat16", bus16.out_sat, e.s16);
          chk("out_valid8", bus8.out_valid, 1);
          chk("out_data8", bus8.out_data, e.d8);
          chk("out_sat8", bus8.out_sat, e.s8);
        end
      end
    end
  end

  task automatic run_sweep(input int sc, input int ec, input logic [15:0] v, input int stall_col,
                           input int nstall, input bit restart, output int fv, output int dc);
    int         ndone = 0;
    int         stall_left = nstall;
    bit         stalling = 1'b0;
    logic [15:0] held = '0;
    int         cyc;
    fv = -1;
    dc = -1;
    push_exp(sc, ec, v);
    bus16.start_col = AW'(sc);
    bus16.end_col   = AW'(ec);
    bus16.vec_in    = v;
    bus16.out_ready = 1'b1;
    bus16.start     = 1'b1;
    tick();
    bus16.start  = 1'b0;
    bus16.vec_in = 16'($urandom);
    cyc = 1;
    while (cyc < 400) begin
      if (restart && cyc == 3) begin
        bus16.start_col = '0;
        bus16.end_col   = '0;
        bus16.vec_in    = 16'($urandom);
        bus16.start     = 1'b1;
      end else begin
        bus16.start = 1'b0;
      end
      if (cyc == 1) chk("busy_after_start", bus16.busy, 1);
      if (bus16.out_valid && fv < 0) fv = cyc;
      if (bus16.done) begin
        ndone++;
        dc = cyc;
        chk("busy_at_done", bus16.busy, 0);
        break;
      end
      if (bus16.out_valid && int'(bus16.out_col) == stall_col && stall_left > 0) begin
        if (stalling) chk("stall_data", bus16.out_data, held);
        else          held = bus16.out_data;
        chk("stall_xbar_en", bus16.xbar_en, 0);
        stalling = 1'b1;
        stall_left--;
        bus16.out_ready = 1'b0;
      end else begin
        bus16.out_ready = 1'b1;
      end
      tick();
      cyc++;
    end
    bus16.start     = 1'b0;
    bus16.out_ready = 1'b1;
    chk("done_count", ndone, 1);
    repeat (4) begin
      tick();
      chk("single_done", {bus16.done, bus16.busy}, 0);
    end
    chk("sb_drained", sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    int  fv, dc;
    bit  found;
    bus16.start     = 1'b0;
    bus16.start_col = '0;
    bus16.end_col   = '0;
    bus16.vec_in    = '0;
    bus16.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_outputs16", {bus16.busy, bus16.xbar_en, bus16.xbar_addr, bus16.xbar_bits,
        bus16.out_valid, bus16.out_data, bus16.out_col, bus16.out_sat, bus16.done, bus16.err}, 0);
    chk("reset_outputs8", {bus8.busy, bus8.out_valid, bus8.out_data, bus8.done, bus8.err}, 0);
    rst_n = 1'b1;
    tick();

    // single column, k=(1,0): 60, timing of first result and done
    k0 = 1; k1 = 0;
    run_sweep(0, 0, 16'hFFFF, -1, 0, 1'b0, fv, dc);
    chk("t1_first_valid_cycle", fv, INPUT_P + XBAR_LAT + 1);
    chk("t1_done_after_handshake", dc - fv, 1);

    // k=(1,1): 1020 on the 16-bit engine, saturated 255 on the 8-bit one
    k0 = 1; k1 = 1;
    run_sweep(0, 0, 16'hFFFF, -1, 0, 1'b0, fv, dc);

    // multi-column sweep with a 3-cycle stall on column 3
    k0 = 2; k1 = 1;
    run_sweep(2, 5, 16'h3A5C, 3, 3, 1'b0, fv, dc);
    chk("t4_first_valid_cycle", fv, INPUT_P + XBAR_LAT + 1);

    // illegal range pulses err and stays idle
    bus16.start_col = 3'd5;
    bus16.end_col   = 3'd2;
    bus16.start     = 1'b1;
    tick();
    bus16.start = 1'b0;
    chk("err_pulse", bus16.err, 1);
    chk("err_busy", {bus16.busy, bus16.out_valid, bus16.done}, 0);
    repeat (4) begin
      tick();
      chk("err_quiet", {bus16.err, bus16.busy, bus16.out_valid, bus16.done}, 0);
    end

    // second start while busy must not restart the sweep
    k0 = 1; k1 = 2;
    run_sweep(1, 4, 16'h9E17, -1, 0, 1'b1, fv, dc);

    // last legal column, heavier weights
    k0 = 3; k1 = 3;
    run_sweep(6, 7, 16'h7F2B, 7, 2, 1'b0, fv, dc);
    k0 = 0; k1 = 1;
    run_sweep(0, 2, 16'(4'h1 | (4'h2 << 4)), -1, 0, 1'b0, fv, dc);

    // asynchronous reset during column 1 issue
    k0 = 2; k1 = 1;
    push_exp(0, 3, 16'hC3A5);
    bus16.start_col = 3'd0;
    bus16.end_col   = 3'd3;
    bus16.vec_in    = 16'hC3A5;
    bus16.start     = 1'b1;
    tick();
    bus16.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (bus16.xbar_en && bus16.xbar_addr == 3'd1) found = 1'b1;
      else tick();
    end
    chk("t6_reached_col1", found, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_reset16", {bus16.busy, bus16.xbar_en, bus16.xbar_addr, bus16.xbar_bits,
        bus16.out_valid, bus16.out_data, bus16.out_col, bus16.out_sat, bus16.done, bus16.err}, 0);
    chk("t6_async_reset8", {bus8.busy, bus8.xbar_en, bus8.out_valid, bus8.out_data, bus8.done}, 0);
    sb_q.delete();
    repeat (3) begin
      tick();
      chk("t6_no_done_in_reset", {bus16.done, bus16.busy}, 0);
    end
    rst_n = 1'b1;
    tick();
    run_sweep(0, 1, 16'h5AF0, -1, 0, 1'b0, fv, dc);
    chk("t6_restart_first_valid", fv, INPUT_P + XBAR_LAT + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
